tcbm_handshake: RTL and testbench



---
 rtl/tcbm_pkg.sv | 39 +++
 rtl/tcbm_sync.sv | 41 ++++
 rtl/tcbm_handshake.sv | 202 ++++++++++++++++++++
 tb/tb_tcbm_handshake.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcbm_pkg.sv
// TCBM drive-side protocol engine: shared codes, status values and states.
// Imported by the synchronizer and the handshake engine.
package tcbm_pkg;

  localparam logic [7:0] TCBM_CMD    = 8'h81;
  localparam logic [7:0] TCBM_LISTEN = 8'h82;
  localparam logic [7:0] TCBM_TALK   = 8'h83;
  localparam logic [7:0] TCBM_SECOND = 8'h84;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_EOI     = 2'b10;
  localparam logic [1:0] ST_BADCODE = 2'b11;

  // TX_DRIVE holds the talk byte on the pins for one
  // cycle before ACK so the host sees settled data.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE_CHK,
    S_RX_HOLD,
    S_TX_FETCH,
    S_TX_DRIVE,
    S_ACK,
    S_RELEASE
  } state_t;

  typedef enum logic {
    PH_CODE,
    PH_PAYLOAD
  } phase_t;

  // What the latched code asks the next payload to do.
  typedef enum logic [1:0] {
    CK_RX,
    CK_TALK,
    CK_BAD
  } kind_t;

endpackage

// File: rtl/tcbm_sync.sv
// Multi-bit flop-chain synchronizer with per-bit edge detect.
// Used for the DAV strobe and for the port A pins.
module tcbm_sync
  import tcbm_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2,
  parameter logic [W-1:0] INIT  = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] prev;

  // Shift the raw input through the chain; prev lags q by one.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= INIT;
      end
      prev <= INIT;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/tcbm_handshake.sv
// TCBM drive-side engine: turns host code/payload pairs into
// rx/tx byte streams with DAV/ACK handshaking and status lines.
module tcbm_handshake
  import tcbm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  input  logic       dav_n,
  output logic       ack_n,
  output logic [1:0] status,
  output logic [7:0] rx_data,
  output logic [1:0] rx_code,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state;
  phase_t        phase;
  kind_t         kind;
  logic [1:0]    code_idx;
  logic [CW-1:0] cnt;

  logic       dav_sync_unused;
  logic       dav_rise;
  logic       dav_fall;
  logic [7:0] pa_q;
  logic [7:0] pa_rise_unused;
  logic [7:0] pa_fall_unused;
  logic       abort;

  // DAV idles high, so its chain resets high to avoid a
  // phantom falling edge right after reset.
  tcbm_sync #(
    .W      (1),
    .STAGES (SYNC_STAGES),
    .INIT   (1'b1)
  ) u_dav_sync (
    .clock (clock),
    .reset (reset),
    .d     (dav_n),
    .q     (dav_sync_unused),
    .rise  (dav_rise),
    .fall  (dav_fall)
  );

  tcbm_sync #(
    .W      (8),
    .STAGES (SYNC_STAGES),
    .INIT   (8'h00)
  ) u_pa_sync (
    .clock (clock),
    .reset (reset),
    .d     (pa_in),
    .q     (pa_q),
    .rise  (pa_rise_unused),
    .fall  (pa_fall_unused)
  );

  // Host released DAV before we acknowledged: drop the transfer.
  assign abort = dav_rise &&
    (state inside {S_CODE_CHK, S_RX_HOLD,
                   S_TX_FETCH, S_TX_DRIVE});

  assign busy = (state != S_IDLE);

  // Protocol sequencer with registered pin and stream outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= PH_CODE;
      kind     <= CK_RX;
      code_idx <= 2'd0;
      cnt      <= '0;
      ack_n    <= 1'b1;
      pa_oe    <= 1'b0;
      pa_out   <= 8'h00;
      status   <= ST_OK;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      rx_code  <= 2'd0;
      tx_ready <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      phase    <= PH_CODE;
      ack_n    <= 1'b1;
      pa_oe    <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (dav_fall) begin
            if (phase == PH_CODE) begin
              state <= S_CODE_CHK;
            end else if (kind == CK_TALK) begin
              state    <= S_TX_FETCH;
              tx_ready <= 1'b1;
              cnt      <= '0;
            end else begin
              state <= S_RX_HOLD;
            end
          end
        end
        S_CODE_CHK: begin
          unique case (1'b1)
            (pa_q == TCBM_CMD): begin
              kind     <= CK_RX;
              code_idx <= 2'd0;
              status   <= ST_OK;
            end
            (pa_q == TCBM_LISTEN): begin
              kind     <= CK_RX;
              code_idx <= 2'd1;
              status   <= ST_OK;
            end
            (pa_q == TCBM_SECOND): begin
              kind     <= CK_RX;
              code_idx <= 2'd2;
              status   <= ST_OK;
            end
            (pa_q == TCBM_TALK): begin
              kind   <= CK_TALK;
              status <= ST_OK;
            end
            default: begin
              kind   <= CK_BAD;
              status <= ST_BADCODE;
            end
          endcase
          ack_n <= 1'b0;
          state <= S_ACK;
        end
        S_RX_HOLD: begin
          if (kind == CK_BAD) begin
            ack_n <= 1'b0;
            state <= S_ACK;
          end else if (!rx_valid) begin
            rx_data  <= pa_q;
            rx_code  <= code_idx;
            rx_valid <= 1'b1;
          end else if (rx_ready) begin
            rx_valid <= 1'b0;
            ack_n    <= 1'b0;
            state    <= S_ACK;
          end
        end
        S_TX_FETCH: begin
          if (tx_valid && tx_ready) begin
            pa_out   <= tx_data;
            pa_oe    <= 1'b1;
            status   <= tx_eoi ? ST_EOI : ST_OK;
            tx_ready <= 1'b0;
            state    <= S_TX_DRIVE;
          end else if (cnt == CNT_LAST) begin
            pa_out   <= 8'h00;
            pa_oe    <= 1'b1;
            status   <= ST_TIMEOUT;
            tx_ready <= 1'b0;
            state    <= S_TX_DRIVE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_TX_DRIVE: begin
          ack_n <= 1'b0;
          state <= S_ACK;
        end
        S_ACK: begin
          if (dav_rise) begin
            ack_n <= 1'b1;
            pa_oe <= 1'b0;
            phase <= (phase == PH_CODE) ?
                     PH_PAYLOAD : PH_CODE;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcbm_handshake.sv
// Directed bench for tcbm_handshake: code/payload transfers,
// talk/timeout, backpressure, bad code, abort and reset.
module tb_tcbm_handshake;

  logic       clock;
  logic       reset;
  logic [7:0] pa_in;
  logic [7:0] pa_out;
  logic       pa_oe;
  logic       dav_n;
  logic       ack_n;
  logic [1:0] status;
  logic [7:0] rx_data;
  logic [1:0] rx_code;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_eoi;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  logic [7:0] last_d;
  logic [1:0] last_c;
  logic       pre_oe;
  logic [7:0] pre_out;
  logic [1:0] pre_st;
  int         bad;

  tcbm_handshake #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pa_in    (pa_in),
    .pa_out   (pa_out),
    .pa_oe    (pa_oe),
    .dav_n    (dav_n),
    .ack_n    (ack_n),
    .status   (status),
    .rx_data  (rx_data),
    .rx_code  (rx_code),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_eoi   (tx_eoi),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every completed rx and tx stream handshake.
  always @(posedge clock) begin
    if (rx_valid && rx_ready) begin
      rx_cnt = rx_cnt + 1;
      last_d = rx_data;
      last_c = rx_code;
    end
    if (tx_valid && tx_ready) begin
      tx_cnt = tx_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drop DAV with a byte and count negedges until ACK.
  task automatic xfer(input string tag,
                      input logic [7:0] b,
                      input int lat);
    int n;
    n = 0;
    pa_in = b;
    dav_n = 1'b0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (ack_n === 1'b0) break;
      pre_oe  = pa_oe;
      pre_out = pa_out;
      pre_st  = status;
    end
    chk(tag, n, lat);
  endtask

  task automatic release_dav(input string tag);
    int n;
    n = 0;
    dav_n = 1'b1;
    while (n < 50) begin
      @(negedge clock);
      n++;
      if (ack_n === 1'b1) break;
    end
    chk(tag, n, 3);
    chk({tag, "_oe"}, pa_oe, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    dav_n    = 1'b1;
    pa_in    = 8'h00;
    rx_ready = 1'b1;
    tx_data  = 8'h00;
    tx_eoi   = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ack", ack_n, 1'b1);
    chk("rst_oe", pa_oe, 1'b0);
    chk("rst_out", pa_out, 8'h00);
    chk("rst_st", status, 2'b00);
    chk("rst_rxv", rx_valid, 1'b0);
    chk("rst_txr", tx_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Listen code then a received byte.
    xfer("t1_code_lat", 8'h82, 4);
    chk("t1_code_st", status, 2'b00);
    chk("t1_busy", busy, 1'b1);
    release_dav("t1_rel_a");
    xfer("t1_pay_lat", 8'h5A, 5);
    chk("t1_rx_cnt", rx_cnt, 1);
    chk("t1_rx_data", last_d, 8'h5A);
    chk("t1_rx_code", last_c, 2'd1);
    chk("t1_st", status, 2'b00);
    release_dav("t1_rel_b");

    // Talk with data ready and EOI.
    xfer("t2_code_lat", 8'h83, 4);
    release_dav("t2_rel_a");
    tx_data  = 8'hC3;
    tx_eoi   = 1'b1;
    tx_valid = 1'b1;
    xfer("t2_pay_lat", 8'hFF, 5);
    chk("t2_pre_oe", pre_oe, 1'b1);
    chk("t2_pre_out", pre_out, 8'hC3);
    chk("t2_pre_st", pre_st, 2'b10);
    chk("t2_out", pa_out, 8'hC3);
    chk("t2_tx_cnt", tx_cnt, 1);
    chk("t2_txr", tx_ready, 1'b0);
    tx_valid = 1'b0;
    tx_eoi   = 1'b0;
    release_dav("t2_rel_b");

    // Talk with no data: timeout after 16 fetch cycles.
    xfer("t3_code_lat", 8'h83, 4);
    release_dav("t3_rel_a");
    xfer("t3_pay_lat", 8'hFF, 20);
    chk("t3_oe", pa_oe, 1'b1);
    chk("t3_out", pa_out, 8'h00);
    chk("t3_st", status, 2'b01);
    chk("t3_tx_cnt", tx_cnt, 1);
    release_dav("t3_rel_b");

    // Command code, payload held off by the core.
    xfer("t4_code_lat", 8'h81, 4);
    release_dav("t4_rel_a");
    rx_ready = 1'b0;
    pa_in = 8'h20;
    dav_n = 1'b0;
    repeat (4) @(negedge clock);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (ack_n !== 1'b1 || rx_valid !== 1'b1 ||
          rx_data !== 8'h20 || rx_code !== 2'd0)
        bad++;
      @(negedge clock);
    end
    chk("t4_hold", bad, 0);
    rx_ready = 1'b1;
    @(negedge clock);
    chk("t4_ack", ack_n, 1'b0);
    chk("t4_rx_cnt", rx_cnt, 2);
    chk("t4_rx_data", last_d, 8'h20);
    chk("t4_rx_code", last_c, 2'd0);
    release_dav("t4_rel_b");

    // Host abort of a held payload resets phase to CODE.
    xfer("ab_code_lat", 8'h82, 4);
    release_dav("ab_rel");
    rx_ready = 1'b0;
    pa_in = 8'h44;
    dav_n = 1'b0;
    repeat (6) @(negedge clock);
    chk("ab_rxv_up", rx_valid, 1'b1);
    dav_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("ab_rxv", rx_valid, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_ack", ack_n, 1'b1);
    chk("ab_rx_cnt", rx_cnt, 2);
    rx_ready = 1'b1;

    // Bad code, discarded payload, then a good code.
    xfer("t5_code_lat", 8'h7F, 4);
    chk("t5_st_bad", status, 2'b11);
    release_dav("t5_rel_a");
    xfer("t5_pay_lat", 8'h99, 4);
    chk("t5_rx_cnt", rx_cnt, 2);
    chk("t5_st_hold", status, 2'b11);
    release_dav("t5_rel_b");
    xfer("t5_good_lat", 8'h84, 4);
    chk("t5_st_ok", status, 2'b00);
    release_dav("t5_rel_c");
    xfer("t5_sec_lat", 8'h33, 5);
    chk("t5_rx_data", last_d, 8'h33);
    chk("t5_rx_code", last_c, 2'd2);
    release_dav("t5_rel_d");

    // Reset while in ACK with DAV still low.
    xfer("t6_code_lat", 8'h82, 4);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_ack", ack_n, 1'b1);
    chk("t6_oe", pa_oe, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_st", status, 2'b00);
    dav_n = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    xfer("t6_code2_lat", 8'h82, 4);
    release_dav("t6_rel_a");
    xfer("t6_pay_lat", 8'h11, 5);
    chk("t6_rx_cnt", rx_cnt, 4);
    chk("t6_rx_data", last_d, 8'h11);
    chk("t6_rx_code", last_c, 2'd1);
    release_dav("t6_rel_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
